// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bundle: fetch requester, data requester and the memory side.
// The arbiter takes the master view; requesters and memory take the slave view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              i_req;
  logic [AW-1:0]     i_addr;
  logic              i_kill;
  logic [DW-1:0]     i_rdata;
  logic              i_ack;

  logic              d_req;
  logic              d_we;
  logic [AW-1:0]     d_addr;
  logic [DW-1:0]     d_wdata;
  logic [DW/8-1:0]   d_be;
  logic [DW-1:0]     d_rdata;
  logic              d_ack;

  logic              stall_if;
  logic              stall_mem;

  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW/8-1:0]   mem_be;
  logic [DW-1:0]     mem_rdata;
  logic              mem_valid;

  modport master (
    input  i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_rdata, mem_valid,
    output i_rdata, i_ack, d_rdata, d_ack, stall_if, stall_mem,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, d_be,
    output mem_rdata, mem_valid,
    input  i_rdata, i_ack, d_rdata, d_ack, stall_if, stall_mem,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single memory port between instruction fetch and data access,
// one transaction at a time, with starvation protection for fetch and branch-flush drop.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  state_t     state, state_d;
  grant_t     grant, grant_d;
  logic       killed, killed_d;
  logic [3:0] starve_cnt, starve_cnt_d;

  logic fetch_elig;
  logic pick_data;
  logic issue;
  logic cap_i, cap_d;
  logic i_ack_d, d_ack_d;
  logic i_ack_q;

  assign fetch_elig = bus.i_req & ~bus.i_kill;
  // Data wins unless fetch has been passed over STARVE_MAX times in a row.
  assign pick_data  = bus.d_req & ~(fetch_elig & (starve_cnt == STARVE_LIMIT));

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state;
    grant_d      = grant;
    killed_d     = killed;
    starve_cnt_d = starve_cnt;
    issue        = 1'b0;
    cap_i        = 1'b0;
    cap_d        = 1'b0;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.d_req || fetch_elig) begin
          issue    = 1'b1;
          killed_d = 1'b0;
          state_d  = WAIT;
          if (pick_data) begin
            grant_d = GNT_D;
            if (fetch_elig && starve_cnt != STARVE_LIMIT)
              starve_cnt_d = starve_cnt + 4'd1;
          end else begin
            grant_d      = GNT_I;
            starve_cnt_d = 4'd0;
          end
        end
      end

      WAIT: begin
        if (grant == GNT_I && bus.i_kill)
          killed_d = 1'b1;
        // The mem_req cycle is the first WAIT cycle; a completion there is illegal.
        if (bus.mem_valid && !bus.mem_req) begin
          if (grant == GNT_I && (killed || bus.i_kill)) begin
            killed_d = 1'b0;
            state_d  = IDLE;
          end else if (grant == GNT_I) begin
            cap_i   = 1'b1;
            i_ack_d = 1'b1;
            state_d = RESP;
          end else begin
            cap_d   = ~bus.mem_we;
            d_ack_d = 1'b1;
            state_d = RESP;
          end
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= GNT_I;
      killed     <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      killed     <= killed_d;
      starve_cnt <= starve_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.d_ack     <= 1'b0;
      i_ack_q       <= 1'b0;
    end else begin
      bus.mem_req <= issue;
      bus.d_ack   <= d_ack_d;
      i_ack_q     <= i_ack_d;
      if (issue) begin
        if (pick_data) begin
          bus.mem_we    <= bus.d_we;
          bus.mem_addr  <= bus.d_addr;
          bus.mem_wdata <= bus.d_wdata;
          bus.mem_be    <= bus.d_be;
        end else begin
          bus.mem_we    <= 1'b0;
          bus.mem_addr  <= bus.i_addr;
          bus.mem_wdata <= '0;
          bus.mem_be    <= '1;
        end
      end
      if (cap_i) bus.i_rdata <= bus.mem_rdata;
      if (cap_d) bus.d_rdata <= bus.mem_rdata;
    end
  end

  // A flush arriving in the response cycle still swallows the fetch acknowledge.
  assign bus.i_ack     = i_ack_q & ~bus.i_kill;
  assign bus.stall_if  = bus.i_req & ~bus.i_ack & ~bus.i_kill;
  assign bus.stall_mem = bus.d_req & ~bus.d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario, memory responses
// driven by hand with fixed gaps so every expected value is known in advance.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input string tag);
    int k = 0;
    while (bus.mem_req !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_checks++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_issue_timeout: mem_req=%b required 1", tag, bus.mem_req);
    end
  endtask

  // Called in the mem_req cycle; returns in the cycle after mem_valid.
  task automatic complete(input logic [31:0] rdata, input int gap);
    repeat (gap) step();
    bus.mem_valid = 1'b1;
    bus.mem_rdata = rdata;
    step();
    bus.mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    n_checks++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL rst_acks: got %b%b want 00", bus.i_ack, bus.d_ack); end
    n_checks++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h/%h want 0/0", bus.i_rdata, bus.d_rdata); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lone_fetch();
    // cycle 0
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0010;
    #1;
    n_checks++; if (bus.stall_if !== 1'b1) begin n_fail++; $display("FAIL lone_stall_c0: got %b want 1", bus.stall_if); end
    step(); // cycle 1
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL lone_mem_req_c1: got %b want 1", bus.mem_req); end
    n_checks++; if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF) begin n_fail++; $display("FAIL lone_we_be: got %b/%h want 0/f", bus.mem_we, bus.mem_be); end
    n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL lone_addr: got %h want 00000010", bus.mem_addr); end
    step(); // cycle 2
    n_checks++; if (bus.mem_req !== 1'b0 || bus.stall_if !== 1'b1) begin n_fail++; $display("FAIL lone_c2: got req=%b stall=%b want 0/1", bus.mem_req, bus.stall_if); end
    bus.mem_valid = 1'b0;
    step(); // cycle 3
    bus.mem_valid = 1'b1; bus.mem_rdata = 32'h0050_0113;
    #1;
    n_checks++; if (bus.i_ack !== 1'b0 || bus.stall_if !== 1'b1) begin n_fail++; $display("FAIL lone_c3: got ack=%b stall=%b want 0/1", bus.i_ack, bus.stall_if); end
    step(); // cycle 4
    bus.mem_valid = 1'b0;
    n_checks++; if (bus.i_ack !== 1'b1) begin n_fail++; $display("FAIL lone_i_ack_c4: got %b want 1", bus.i_ack); end
    n_checks++; if (bus.i_rdata !== 32'h0050_0113) begin n_fail++; $display("FAIL lone_i_rdata: got %h want 00500113", bus.i_rdata); end
    n_checks++; if (bus.stall_if !== 1'b0) begin n_fail++; $display("FAIL lone_stall_c4: got %b want 0", bus.stall_if); end
    step(); // cycle 5
    bus.i_req = 1'b0;
    n_checks++; if (bus.i_ack !== 1'b0) begin n_fail++; $display("FAIL lone_ack_width: got %b want 0", bus.i_ack); end
    step();
  endtask

  task automatic test_simultaneous();
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    step(); // mem_req cycle
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL sim_data_first: got req=%b addr=%h want 1/00000100", bus.mem_req, bus.mem_addr); end
    complete(32'hCAFE_0001, 1);
    n_checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL sim_d_ack: got ack=%b rdata=%h want 1/cafe0001", bus.d_ack, bus.d_rdata); end
    n_checks++; if (bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b0) begin n_fail++; $display("FAIL sim_stalls: got if=%b mem=%b want 1/0", bus.stall_if, bus.stall_mem); end
    step();
    bus.d_req = 1'b0;
    step();
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h20) begin n_fail++; $display("FAIL sim_fetch_next: got req=%b addr=%h want 1/00000020", bus.mem_req, bus.mem_addr); end
    complete(32'h1111_1111, 1);
    n_checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL sim_i_ack: got ack=%b rdata=%h want 1/11111111", bus.i_ack, bus.i_rdata); end
    step();
    bus.i_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr [5] = '{32'h200, 32'h200, 32'h200, 32'h40, 32'h200};
    logic [3:0]  exp_cnt  [5] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd0};
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
    for (int t = 0; t < 5; t++) begin
      logic [31:0] rd;
      wait_issue("starve");
      n_checks++; if (bus.mem_addr !== exp_addr[t]) begin n_fail++; $display("FAIL starve_grant%0d: got %h want %h", t, bus.mem_addr, exp_addr[t]); end
      n_checks++; if (dut.starve_cnt !== exp_cnt[t]) begin n_fail++; $display("FAIL starve_cnt%0d: got %0d want %0d", t, dut.starve_cnt, exp_cnt[t]); end
      rd = (t == 3) ? 32'h1111_0003 : 32'h0000_D000 + 32'(t);
      complete(rd, 1);
      if (t == 3) begin
        n_checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== rd) begin n_fail++; $display("FAIL starve_i_ack%0d: got ack=%b rdata=%h want 1/%h", t, bus.i_ack, bus.i_rdata, rd); end
      end else begin
        n_checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== rd) begin n_fail++; $display("FAIL starve_d_ack%0d: got ack=%b rdata=%h want 1/%h", t, bus.d_ack, bus.d_rdata, rd); end
      end
      step();
      if (t == 3) bus.i_req = 1'b0;
      if (t == 4) bus.d_req = 1'b0;
    end
    step();
  endtask

  task automatic test_store();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'h3;
    wait_issue("store");
    n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_be !== 4'h3) begin n_fail++; $display("FAIL store_we_be: got %b/%h want 1/3", bus.mem_we, bus.mem_be); end
    n_checks++; if (bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_addr !== 32'h300) begin n_fail++; $display("FAIL store_fields: got %h@%h want deadbeef@00000300", bus.mem_wdata, bus.mem_addr); end
    complete(32'h1234_5678, 2);
    n_checks++; if (bus.d_ack !== 1'b1) begin n_fail++; $display("FAIL store_ack: got %b want 1", bus.d_ack); end
    n_checks++; if (bus.d_rdata !== 32'h0000_D004) begin n_fail++; $display("FAIL store_rdata_kept: got %h want 0000d004", bus.d_rdata); end
    step();
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
    step();
  endtask

  task automatic test_kill();
    bus.i_req = 1'b1; bus.i_addr = 32'h50;
    wait_issue("kill_wait");
    step(); // first plain WAIT cycle
    bus.i_kill = 1'b1;
    step();
    bus.i_kill = 1'b0; bus.i_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
    bus.mem_valid = 1'b1; bus.mem_rdata = 32'h0000_0BAD;
    step(); // should be back in IDLE
    bus.mem_valid = 1'b0;
    n_checks++; if (bus.i_ack !== 1'b0) begin n_fail++; $display("FAIL kill_no_ack: got %b want 0", bus.i_ack); end
    n_checks++; if (bus.i_rdata !== 32'h1111_0003) begin n_fail++; $display("FAIL kill_rdata_kept: got %h want 11110003", bus.i_rdata); end
    n_checks++; if (bus.stall_mem !== 1'b1) begin n_fail++; $display("FAIL kill_stall_mem: got %b want 1", bus.stall_mem); end
    step();
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h400) begin n_fail++; $display("FAIL kill_next_issue: got req=%b addr=%h want 1/00000400", bus.mem_req, bus.mem_addr); end
    complete(32'h0000_4444, 1);
    n_checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h0000_4444) begin n_fail++; $display("FAIL kill_d_ack: got ack=%b rdata=%h want 1/00004444", bus.d_ack, bus.d_rdata); end
    step();
    bus.d_req = 1'b0;
    step();

    // Flush landing in the response cycle
    bus.i_req = 1'b1; bus.i_addr = 32'h60;
    wait_issue("kill_resp");
    complete(32'h0000_AAAA, 1);
    bus.i_kill = 1'b1;
    #1;
    n_checks++; if (bus.i_ack !== 1'b0) begin n_fail++; $display("FAIL kill_resp_ack: got %b want 0", bus.i_ack); end
    n_checks++; if (bus.i_rdata !== 32'h0000_AAAA) begin n_fail++; $display("FAIL kill_resp_rdata: got %h want 0000aaaa", bus.i_rdata); end
    n_checks++; if (bus.stall_if !== 1'b0) begin n_fail++; $display("FAIL kill_resp_stall: got %b want 0", bus.stall_if); end
    step();
    bus.i_kill = 1'b0; bus.i_req = 1'b0;
    step();
  endtask

  task automatic test_early_valid();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h700;
    wait_issue("early");
    bus.mem_valid = 1'b1; bus.mem_rdata = 32'hEEEE_0000;
    step();
    bus.mem_valid = 1'b0;
    n_checks++; if (bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL early_ignored: got d_ack=%b want 0", bus.d_ack); end
    step();
    n_checks++; if (bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL early_still_wait: got d_ack=%b want 0", bus.d_ack); end
    complete(32'h7777_0000, 0);
    n_checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h7777_0000) begin n_fail++; $display("FAIL early_real: got ack=%b rdata=%h want 1/77770000", bus.d_ack, bus.d_rdata); end
    step();
    bus.d_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
    wait_issue("rst_mid");
    step();
    #2;
    rst = 1'b1; bus.d_req = 1'b0;
    #1;
    n_checks++; if (bus.mem_addr !== 32'h0 || bus.d_rdata !== 32'h0 || bus.i_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_async: got addr=%h d=%h i=%h want 0/0/0", bus.mem_addr, bus.d_rdata, bus.i_rdata); end
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (bus.d_ack !== 1'b0 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_no_ack%0d: got ack=%b req=%b want 0/0", k, bus.d_ack, bus.mem_req); end
    end
    bus.d_req = 1'b1; bus.d_addr = 32'h600;
    step();
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h600) begin n_fail++; $display("FAIL rst_reissue: got req=%b addr=%h want 1/00000600", bus.mem_req, bus.mem_addr); end
    complete(32'h600D_F00D, 1);
    n_checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h600D_F00D) begin n_fail++; $display("FAIL rst_reissue_ack: got ack=%b rdata=%h want 1/600df00d", bus.d_ack, bus.d_rdata); end
    step();
    bus.d_req = 1'b0;
    step();
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0; bus.i_kill = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_rdata = '0; bus.mem_valid = 1'b0;
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_kill();
    test_early_valid();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port of the pipelined RISC-V core between the fetch stage (instruction reads) and the memory stage (data loads/stores). It issues one transaction at a time to a variable-latency memory and returns read data with a one-cycle acknowledge. It exports the fetch and memory stall terms consumed by the hazard logic. It discards fetches flushed by a taken branch (PCSrcE).

## Interface
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 bits)
- STARVE_MAX, 3, consecutive data-over-fetch grants allowed before fetch is forced to win (1..15)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_req  in  1  fetch request; held with i_addr until i_ack or i_kill
- i_addr  in  AW  fetch address
- i_kill  in  1  flush current/pending fetch (taken branch)
- i_rdata  out  DW  fetched instruction, valid in i_ack cycle
- i_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_be  in  DW/8  store byte enables
- d_rdata  out  DW  load data, valid in d_ack cycle
- d_ack  out  1  one-cycle data completion pulse
- stall_if  out  1  i_req & ~i_ack & ~i_kill (combinational)
- stall_mem  out  1  d_req & ~d_ack (combinational)
- mem_req  out  1  one-cycle issue strobe
- mem_we, mem_addr, mem_wdata, mem_be  out  1/AW/DW/DW/8  registered transaction fields, held from issue until next issue
- mem_rdata  in  DW  memory read data, valid with mem_valid
- mem_valid  in  1  completion of outstanding transaction, at least 1 cycle after mem_req

## Operation
- States: IDLE, WAIT, RESP. Registers: grant (I/D), killed flag, starvation counter (4 bits).
- IDLE: eligible fetch = i_req & ~i_kill. If no eligible request, stay. Otherwise choose a winner, register the fields, set mem_req=1 for the next cycle, go to WAIT.
- Priority: data beats fetch, unless the counter equals STARVE_MAX while both requests are pending; then fetch wins.
- Counter: +1 on each data grant made while an eligible fetch was pending, saturating at STARVE_MAX. It clears on any fetch grant.
- Fetch issue drives mem_we=0 and mem_be=all ones. Data issue copies d_we, d_addr, d_wdata, d_be.
- WAIT: mem_valid is ignored in the mem_req cycle (protocol violation). On a later mem_valid:
  - grant=I, not killed: capture mem_rdata into i_rdata, go to RESP.
  - grant=D: capture into d_rdata for loads only (stores leave d_rdata unchanged), go to RESP.
  - grant=I and killed: drop the data, clear killed, go to IDLE with no ack.
- i_kill in any WAIT cycle with grant=I (including the mem_req cycle) sets killed. i_kill has no effect on data transactions.
- RESP: pulse i_ack or d_ack for exactly one cycle. No arbitration occurs in RESP. Return to IDLE.
  - i_kill in RESP with grant=I suppresses i_ack (i_rdata still updated).
- Reset mid-transaction: everything returns to IDLE immediately and the outstanding mem_valid is never consumed. The memory is reset by the same rst.
- Reset values: all outputs 0, state IDLE, counter 0, killed 0.

## Timing
- Requests are sampled in IDLE at edge N. mem_req is high in cycle N+1.
- mem_valid arrives at the earliest in cycle N+2. The ack is high in the cycle after mem_valid (N+3 at the earliest).
- Minimum occupancy is 3 cycles; throughput is at most one transaction per 4 cycles (issue, wait, resp, idle).
- i_ack/d_ack are registered and the rdata outputs are stable in the ack cycle. Requesters drop or change requests no earlier than the cycle after ack.
- stall_if and stall_mem are combinational from inputs and ack registers, with no added latency.
- If i_req and d_req both rise in the same IDLE cycle, one transaction is issued and the loser stays stalled until the next IDLE.

## Test plan
- Lone fetch: i_req=1, i_addr=0x00000010, mem_valid 2 cycles after mem_req with rdata=0x00500113 -> mem_req in cycle 1, mem_we=0, mem_be=0xF, i_ack in cycle 4 with i_rdata=0x00500113, stall_if high cycles 0-3.
- Simultaneous requests: i_req and d_req (load at 0x100) in the same cycle -> data issued first, d_ack, then fetch issued at the next IDLE, stall_if held throughout.
- Starvation, STARVE_MAX=3: d_req held continuously with i_req pending -> 3 data grants, then a fetch grant, then the counter reads 0 and data wins again.
- Store: d_we=1, d_be=0x3, d_wdata=0xDEADBEEF -> mem_we=1, mem_be=0x3 on issue, d_ack pulses, d_rdata unchanged from prior load.
- Kill: fetch outstanding, i_kill pulsed in WAIT -> no i_ack, state reaches IDLE one cycle after mem_valid, next pending d_req issued from IDLE. i_kill in RESP -> i_ack stays 0.
- Reset mid-WAIT: rst asserted while a data load is outstanding -> all outputs 0 asynchronously, no d_ack after release, first request after release issues normally.
